// File: rtl/sequential_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives operands and start; the slave (divider) drives status and results.
interface sequential_divider_if #(
    parameter int BITSIZE = 16
) ();
    logic                      start;
    logic signed [BITSIZE-1:0] num;
    logic signed [BITSIZE-1:0] den;
    logic                      busy;
    logic                      done;
    logic signed [BITSIZE-1:0] out;
    logic                      sat;
    logic                      div_zero;

    modport master (
        output start, num, den,
        input  busy, done, out, sat, div_zero
    );

    modport slave (
        input  start, num, den,
        output busy, done, out, sat, div_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// Signed fixed-point restoring divider: out = num / den in Q(BITSIZE-2), one quotient
// bit per bclk, truncating toward zero, with saturation and a division-by-zero flag.
module sequential_divider #(
    parameter int BITSIZE  = 16,
    parameter int FRACBITS = BITSIZE - 2
) (
    input  logic                 bclk,
    input  logic                 rst_n,
    sequential_divider_if.slave  bus
);

    localparam int Q     = BITSIZE + FRACBITS;
    localparam int CNT_W = $clog2(Q + 1);

    localparam logic [Q-1:0] POS_LIM = (Q'(1) << (BITSIZE - 1)) - Q'(1);
    localparam logic [Q-1:0] NEG_LIM = Q'(1) << (BITSIZE - 1);
    localparam logic [BITSIZE-1:0] MAX_POS = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] MIN_NEG = {1'b1, {(BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [BITSIZE:0]          r_den_mag;
    logic [Q-1:0]              r_dvd;
    logic [Q-1:0]              r_quo;
    logic [BITSIZE-1:0]        r_rem;
    logic                      r_sign;
    logic                      r_num_neg;
    logic                      r_dz;
    logic                      r_done;
    logic                      r_sat;
    logic                      r_div_zero;
    logic signed [BITSIZE-1:0] r_out;

    logic                      w_accept;
    logic [BITSIZE:0]          w_num_mag;
    logic [BITSIZE:0]          w_den_mag;
    logic [BITSIZE:0]          w_rem_sh;
    logic                      w_ge;
    logic [BITSIZE:0]          w_fix;

    // One extra bit so that the most negative sample has an exact magnitude.
    function automatic logic [BITSIZE:0] magnitude(input logic signed [BITSIZE-1:0] v);
        logic signed [BITSIZE:0] e;
        e = {v[BITSIZE-1], v};
        return (e < 0) ? unsigned'(-e) : unsigned'(e);
    endfunction

    // Returns {sat, out}: clip the unsigned quotient into the signed output range.
    function automatic logic [BITSIZE:0] saturate(input logic [Q-1:0] q, input logic neg);
        logic [BITSIZE-1:0] lo;
        lo = q[BITSIZE-1:0];
        if (!neg && (q > POS_LIM)) begin
            return {1'b1, MAX_POS};
        end else if (neg && (q > NEG_LIM)) begin
            return {1'b1, MIN_NEG};
        end else begin
            return {1'b0, (neg ? -lo : lo)};
        end
    endfunction

    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_num_mag = magnitude(bus.num);
    assign w_den_mag = magnitude(bus.den);
    assign w_rem_sh  = {r_rem, r_dvd[Q-1]};
    assign w_ge      = (w_rem_sh >= r_den_mag);
    assign w_fix     = saturate(r_quo, r_sign);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_out      <= '0;
            r_sat      <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == FIX);
            if (w_accept) begin
                r_cnt <= CNT_W'(Q);
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_state == FIX) begin
                r_div_zero <= r_dz;
                if (r_dz) begin
                    r_out <= r_num_neg ? MIN_NEG : MAX_POS;
                    r_sat <= 1'b0;
                end else begin
                    r_sat <= w_fix[BITSIZE];
                    r_out <= w_fix[BITSIZE-1:0];
                end
            end
        end
    end

    // Working registers are fully reloaded on every accepted start.
    always_ff @(posedge bclk) begin
        if (w_accept) begin
            r_sign    <= bus.num[BITSIZE-1] ^ bus.den[BITSIZE-1];
            r_num_neg <= bus.num[BITSIZE-1];
            r_dz      <= (bus.den == '0);
            r_den_mag <= w_den_mag;
            r_dvd     <= Q'({w_num_mag, {FRACBITS{1'b0}}});
            r_rem     <= '0;
            r_quo     <= '0;
        end else if (r_state == RUN) begin
            r_dvd <= {r_dvd[Q-2:0], 1'b0};
            r_quo <= {r_quo[Q-2:0], w_ge};
            r_rem <= w_ge ? BITSIZE'(w_rem_sh - r_den_mag) : w_rem_sh[BITSIZE-1:0];
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.out      = r_out;
    assign bus.sat      = r_sat;
    assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed and random divisions with a
// result scoreboard, handshake corner cases and asynchronous reset mid-operation.
module tb_sequential_divider;

    localparam int BITSIZE  = 16;
    localparam int FRACBITS = BITSIZE - 2;
    localparam int LAT      = BITSIZE + FRACBITS + 1;

    typedef struct packed {
        logic signed [BITSIZE-1:0] out;
        logic                      sat;
        logic                      dz;
    } exp_t;

    logic bclk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    sequential_divider_if #(.BITSIZE(BITSIZE)) dif ();

    sequential_divider #(.BITSIZE(BITSIZE), .FRACBITS(FRACBITS)) dut (
        .bclk  (bclk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 bclk = ~bclk;

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "simulation timeout");
    end

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge bclk) begin
        if (rst_n && dif.done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done out=%0d sat=%0b dz=%0b", dif.out, dif.sat, dif.div_zero);
            end else begin
                mon_e = sb.pop_front();
                if (dif.out !== mon_e.out || dif.sat !== mon_e.sat || dif.div_zero !== mon_e.dz) begin
                    failures++;
                    $display("FAIL result got out=%0d sat=%0b dz=%0b want out=%0d sat=%0b dz=%0b",
                             dif.out, dif.sat, dif.div_zero, mon_e.out, mon_e.sat, mon_e.dz);
                end
            end
        end
    end

    function automatic exp_t model(input logic signed [BITSIZE-1:0] n, input logic signed [BITSIZE-1:0] d);
        exp_t   r;
        longint an;
        longint ad;
        longint q;
        bit     neg;
        r.dz  = 1'b0;
        r.sat = 1'b0;
        if (d == 0) begin
            r.dz  = 1'b1;
            r.out = (n >= 0) ? 16'h7FFF : 16'h8000;
        end else begin
            an  = (n < 0) ? -longint'(n) : longint'(n);
            ad  = (d < 0) ? -longint'(d) : longint'(d);
            q   = (an * (longint'(1) << FRACBITS)) / ad;
            neg = (n < 0) != (d < 0);
            if (!neg && q > 32767) begin
                r.out = 16'h7FFF;
                r.sat = 1'b1;
            end else if (neg && q > 32768) begin
                r.out = 16'h8000;
                r.sat = 1'b1;
            end else begin
                r.out = neg ? 16'(-q) : 16'(q);
            end
        end
        return r;
    endfunction

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        @(negedge bclk);
        while (dif.busy && cyc < 100) begin
            @(negedge bclk);
            cyc++;
        end
    endtask

    task automatic do_div(input logic signed [BITSIZE-1:0] n, input logic signed [BITSIZE-1:0] d,
                          input exp_t e, input string name);
        int cyc;
        wait_idle();
        dif.start = 1'b1;
        dif.num   = n;
        dif.den   = d;
        sb.push_back(e);
        @(posedge bclk);
        #1;
        dif.start = 1'b0;
        dif.num   = 16'($urandom);
        dif.den   = 16'($urandom);
        cyc = 0;
        while (!dif.done && cyc < 100) begin
            @(posedge bclk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== LAT) begin
            failures++;
            $display("FAIL latency_%s got=%0d want=%0d", name, cyc, LAT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge bclk);
        #1;
        checks++; if (dif.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b want=0", dif.busy); end
        checks++; if (dif.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b want=0", dif.done); end
        checks++; if (dif.out !== 16'sd0)    begin failures++; $display("FAIL reset_out got=%0d want=0", dif.out); end
        checks++; if (dif.sat !== 1'b0)      begin failures++; $display("FAIL reset_sat got=%b want=0", dif.sat); end
        checks++; if (dif.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b want=0", dif.div_zero); end
        @(negedge bclk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_div(16'sd8192,  16'sd16384,  '{16'sd8192,  1'b0, 1'b0}, "pp");
        do_div(-16'sd8192, 16'sd16384,  '{-16'sd8192, 1'b0, 1'b0}, "np");
        do_div(16'sd8192,  -16'sd16384, '{-16'sd8192, 1'b0, 1'b0}, "pn");
        do_div(-16'sd8192, -16'sd16384, '{16'sd8192,  1'b0, 1'b0}, "nn");
    endtask

    task automatic test_truncation();
        do_div(16'sd1,     16'sd3,     '{16'sd5461,  1'b0, 1'b0}, "one_third");
        do_div(-16'sd1,    16'sd3,     '{-16'sd5461, 1'b0, 1'b0}, "neg_third");
        do_div(16'sd16384, 16'sd16384, '{16'sd16384, 1'b0, 1'b0}, "unity");
        do_div(16'sd0,     16'sd77,    '{16'sd0,     1'b0, 1'b0}, "zero_num");
    endtask

    task automatic test_saturation();
        do_div(16'sd16384, 16'sd8192,  '{16'sh7FFF, 1'b1, 1'b0}, "two");
        do_div(16'sh8000,  16'sd16384, '{16'sh8000, 1'b0, 1'b0}, "min_exact");
        do_div(16'sh8000,  16'sd8192,  '{16'sh8000, 1'b1, 1'b0}, "min_sat");
        do_div(16'sd32767, 16'sd1,     '{16'sh7FFF, 1'b1, 1'b0}, "max_by_one");
    endtask

    task automatic test_div_zero();
        do_div(16'sd100,   16'sd0,     '{16'sh7FFF, 1'b0, 1'b1}, "dz_pos");
        do_div(-16'sd5,    16'sd0,     '{16'sh8000, 1'b0, 1'b1}, "dz_neg");
        do_div(16'sd8192,  16'sd16384, '{16'sd8192, 1'b0, 1'b0}, "dz_clear");
    endtask

    task automatic test_back_to_back();
        logic signed [BITSIZE-1:0] ns[3];
        logic signed [BITSIZE-1:0] ds[3];
        exp_t                      es[3];
        int                        cyc;
        ns[0] = 16'sd8192;  ds[0] = 16'sd16384; es[0] = '{16'sd8192,  1'b0, 1'b0};
        ns[1] = -16'sd1;    ds[1] = 16'sd3;     es[1] = '{-16'sd5461, 1'b0, 1'b0};
        ns[2] = 16'sd16384; ds[2] = 16'sd8192;  es[2] = '{16'sh7FFF,  1'b1, 1'b0};
        wait_idle();
        dif.start = 1'b1;
        dif.num   = ns[0];
        dif.den   = ds[0];
        sb.push_back(es[0]);
        @(posedge bclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            while (!dif.done && cyc < 100) begin
                @(posedge bclk);
                #1;
                cyc++;
            end
            checks++;
            if (cyc !== LAT) begin
                failures++;
                $display("FAIL b2b_latency_%0d got=%0d want=%0d", i, cyc, LAT);
            end
            if (i < 2) begin
                dif.num = ns[i+1];
                dif.den = ds[i+1];
                sb.push_back(es[i+1]);
                @(posedge bclk);
                #1;
                checks++;
                if (dif.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_accept_%0d busy=%b want=1", i, dif.busy);
                end
            end else begin
                dif.start = 1'b0;
            end
        end
    endtask

    task automatic test_ignore_mid_run();
        int cyc;
        int extra;
        wait_idle();
        dif.start = 1'b1;
        dif.num   = 16'sd8192;
        dif.den   = 16'sd16384;
        sb.push_back('{16'sd8192, 1'b0, 1'b0});
        @(posedge bclk);
        #1;
        dif.start = 1'b0;
        cyc = 0;
        repeat (5) begin
            @(posedge bclk);
            #1;
            cyc++;
        end
        dif.start = 1'b1;
        dif.num   = -16'sd5;
        dif.den   = 16'sd0;
        @(posedge bclk);
        #1;
        cyc++;
        dif.start = 1'b0;
        dif.num   = 16'sd100;
        dif.den   = 16'sd3;
        while (!dif.done && cyc < 100) begin
            @(posedge bclk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== LAT) begin
            failures++;
            $display("FAIL ignore_latency got=%0d want=%0d", cyc, LAT);
        end
        extra = 0;
        repeat (40) begin
            @(posedge bclk);
            #1;
            if (dif.done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL ignore_extra_done got=%0d want=0", extra);
        end
    endtask

    task automatic test_reset_mid_op();
        int extra;
        wait_idle();
        dif.start = 1'b1;
        dif.num   = -16'sd1;
        dif.den   = 16'sd3;
        @(posedge bclk);
        #1;
        dif.start = 1'b0;
        repeat (10) @(posedge bclk);
        @(negedge bclk);
        rst_n = 1'b0;
        #1;
        checks++; if (dif.busy !== 1'b0)     begin failures++; $display("FAIL midrst_busy got=%b want=0", dif.busy); end
        checks++; if (dif.done !== 1'b0)     begin failures++; $display("FAIL midrst_done got=%b want=0", dif.done); end
        checks++; if (dif.out !== 16'sd0)    begin failures++; $display("FAIL midrst_out got=%0d want=0", dif.out); end
        checks++; if (dif.sat !== 1'b0)      begin failures++; $display("FAIL midrst_sat got=%b want=0", dif.sat); end
        checks++; if (dif.div_zero !== 1'b0) begin failures++; $display("FAIL midrst_dz got=%b want=0", dif.div_zero); end
        repeat (3) @(posedge bclk);
        @(negedge bclk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(posedge bclk);
            #1;
            if (dif.done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL midrst_done_after_release got=%0d want=0", extra);
        end
        do_div(16'sd8192, -16'sd16384, '{-16'sd8192, 1'b0, 1'b0}, "after_reset");
    endtask

    task automatic test_random();
        logic signed [BITSIZE-1:0] n;
        logic signed [BITSIZE-1:0] d;
        for (int i = 0; i < 10; i++) begin
            n = 16'($urandom);
            d = 16'($urandom);
            d = d >>> $urandom_range(0, 14);
            do_div(n, d, model(n, d), "random");
        end
    endtask

    initial begin
        dif.start = 1'b0;
        dif.num   = '0;
        dif.den   = '0;
        test_reset();
        test_basic();
        test_truncation();
        test_saturation();
        test_div_zero();
        test_back_to_back();
        test_ignore_mid_run();
        test_reset_mid_op();
        test_random();
        wait_idle();
        @(negedge bclk);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL missing_results got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
